// File: rtl/qpsk_frame_sync_pkg.sv
// ============================================================================
//  Package  : qpsk_pkg
//  Purpose  : Shared types and phase-ambiguity helpers for qpsk_frame_sync.
//             FRAME_SYNC_SWAP_EN adds the four I/Q-swapped hypotheses.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package qpsk_pkg;

`ifdef FRAME_SYNC_SWAP_EN
  localparam int NUM_HYP = 8;
`else
  localparam int NUM_HYP = 4;
`endif

  typedef enum logic [1:0] {
    SYNC_HUNT   = 2'd0,
    SYNC_VERIFY = 2'd1,
    SYNC_LOCK   = 2'd2
  } sync_state_t;

  typedef struct packed {
    logic       swap;
    logic [1:0] rot;
  } hyp_t;

  // Hypothesis index {swap, rot} to struct form.
  function automatic hyp_t hyp_from_index(input logic [2:0] idx);
    hyp_t h;
    h.swap = idx[2];
    h.rot  = idx[1:0];
    return h;
  endfunction

  // Expected received sign bits for one transmitted symbol: swap first, then rotate CCW.
  function automatic logic [1:0] rotate_exp(input hyp_t h, input logic ti, input logic tq);
    logic a, b;
    logic [1:0] r;
    a = h.swap ? tq : ti;
    b = h.swap ? ti : tq;
    case (h.rot)
      2'd0:    r = {a, b};
      2'd1:    r = {~b, a};
      2'd2:    r = {~a, ~b};
      default: r = {b, ~a};
    endcase
    return r;
  endfunction

  // Inverse of rotate_exp: undo the rotation, then undo the swap.
  function automatic logic [1:0] derotate(input hyp_t h, input logic ri, input logic rq);
    logic a, b;
    case (h.rot)
      2'd0:    begin a = ri;  b = rq;  end
      2'd1:    begin a = rq;  b = ~ri; end
      2'd2:    begin a = ~ri; b = ~rq; end
      default: begin a = ~rq; b = ri;  end
    endcase
    return h.swap ? {b, a} : {a, b};
  endfunction

endpackage

`default_nettype wire

// File: rtl/qpsk_frame_sync_sof_correlator.sv
// ============================================================================
//  Module   : sof_correlator
//  Purpose  : SOF window, per-hypothesis agreement count and best-of select.
//             Number of hypotheses follows FRAME_SYNC_SWAP_EN via qpsk_pkg.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sof_correlator
  import qpsk_pkg::*;
#(
  parameter int                 SOF_LEN = 26,
  parameter logic [SOF_LEN-1:0] SOF_I   = 26'h3278428,
  parameter logic [SOF_LEN-1:0] SOF_Q   = 26'h272d17d,
  parameter int                 THRESH  = 48,
  localparam int                SW      = $clog2(2*SOF_LEN+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sym_valid,
  input  logic          sym_i,
  input  logic          sym_q,
  output hyp_t          best_hyp,
  output logic [SW-1:0] best_score,
  output logic          hit
);

  logic [SOF_LEN-1:0] win_i, win_q;
  logic [SOF_LEN-1:0] cur_i, cur_q;
  logic [SW-1:0]      hyp_score [NUM_HYP];
  logic [2:0]         best_idx;

  // Correlation always sees the window including the symbol arriving now.
  assign cur_i = {win_i[SOF_LEN-2:0], sym_i};
  assign cur_q = {win_q[SOF_LEN-2:0], sym_q};

  // Shift the sign-bit windows once per valid symbol.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_i <= '0;
      win_q <= '0;
    end else if (sym_valid) begin
      win_i <= cur_i;
      win_q <= cur_q;
    end
  end

  for (genvar h = 0; h < NUM_HYP; h++) begin : g_hyp
    logic [SOF_LEN-1:0] exp_i, exp_q;
    logic [SOF_LEN-1:0] agree_i, agree_q;
    logic [SW-1:0]      cnt;

    for (genvar k = 0; k < SOF_LEN; k++) begin : g_bit
      assign {exp_i[k], exp_q[k]} = rotate_exp(hyp_from_index(3'(h)), SOF_I[k], SOF_Q[k]);
    end

    assign agree_i = cur_i ~^ exp_i;
    assign agree_q = cur_q ~^ exp_q;

    // Popcount of agreeing I and Q bits for this hypothesis.
    always_comb begin
      cnt = '0;
      for (int k = 0; k < SOF_LEN; k++) begin
        cnt = cnt + {{(SW-1){1'b0}}, agree_i[k]} + {{(SW-1){1'b0}}, agree_q[k]};
      end
    end

    assign hyp_score[h] = cnt;
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    best_score = hyp_score[0];
    best_idx   = 3'd0;
    for (int h = 1; h < NUM_HYP; h++) begin
      if (hyp_score[h] > best_score) begin
        best_score = hyp_score[h];
        best_idx   = 3'(h);
      end
    end
  end

  assign best_hyp = hyp_from_index(best_idx);
  assign hit      = (best_score >= SW'(THRESH));

endmodule

`default_nettype wire

// File: rtl/qpsk_frame_sync.sv
// ============================================================================
//  Module   : qpsk_frame_sync
//  Purpose  : QPSK SOF search with HUNT/VERIFY/LOCK flywheel and payload
//             de-rotation. Define FRAME_SYNC_SWAP_EN for I/Q-swap hypotheses.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module qpsk_frame_sync
  import qpsk_pkg::*;
#(
  parameter int                 SOF_LEN     = 26,
  parameter logic [SOF_LEN-1:0] SOF_I       = 26'h3278428,
  parameter logic [SOF_LEN-1:0] SOF_Q       = 26'h272d17d,
  parameter int                 PAYLOAD_LEN = 63,
  parameter int                 THRESH      = 48,
  parameter int                 CONFIRM     = 2,
  parameter int                 MISS_MAX    = 3,
  localparam int                SW          = $clog2(2*SOF_LEN+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sym_valid,
  input  logic          sym_i,
  input  logic          sym_q,
  output logic          out_valid,
  output logic [1:0]    out_data,
  output logic          out_first,
  output logic          out_last,
  output logic          sof_pulse,
  output logic          locked,
  output logic [1:0]    sync_state,
  output logic [1:0]    rot,
  output logic          swap,
  output logic          hyp_change,
  output logic [SW-1:0] score
);

  localparam int P  = SOF_LEN + PAYLOAD_LEN;
  localparam int PW = $clog2(P);
  localparam int CW = $clog2(CONFIRM + 1);
  localparam int MW = $clog2(MISS_MAX + 1);

  localparam logic [1:0] ST_HUNT   = SYNC_HUNT;
  localparam logic [1:0] ST_VERIFY = SYNC_VERIFY;
  localparam logic [1:0] ST_LOCK   = SYNC_LOCK;

  logic [1:0]    state;
  logic [PW-1:0] pos;
  logic [CW-1:0] conf;
  logic [MW-1:0] miss;
  hyp_t          hyp;

  hyp_t          best_hyp;
  logic [SW-1:0] best_score;
  logic          hit;

  logic          at_end;
  logic [CW-1:0] conf_inc;
  logic [MW-1:0] miss_inc;

  sof_correlator #(
    .SOF_LEN (SOF_LEN),
    .SOF_I   (SOF_I),
    .SOF_Q   (SOF_Q),
    .THRESH  (THRESH)
  ) u_corr (
    .clk        (clk),
    .rst        (rst),
    .sym_valid  (sym_valid),
    .sym_i      (sym_i),
    .sym_q      (sym_q),
    .best_hyp   (best_hyp),
    .best_score (best_score),
    .hit        (hit)
  );

  assign at_end   = (pos == PW'(P - 1));
  assign conf_inc = conf + CW'(1);
  assign miss_inc = miss + MW'(1);

  // Frame tracking and registered outputs; everything advances only on sym_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_HUNT;
      pos        <= '0;
      conf       <= '0;
      miss       <= '0;
      hyp        <= '0;
      out_valid  <= 1'b0;
      out_data   <= 2'b00;
      out_first  <= 1'b0;
      out_last   <= 1'b0;
      sof_pulse  <= 1'b0;
      hyp_change <= 1'b0;
      score      <= '0;
    end else begin
      out_valid  <= 1'b0;
      sof_pulse  <= 1'b0;
      hyp_change <= 1'b0;
      if (sym_valid) begin
        score <= best_score;
        pos   <= at_end ? '0 : pos + PW'(1);

        // Payload uses the hypothesis latched at the preceding SOF end.
        if (state != ST_HUNT && pos < PW'(PAYLOAD_LEN)) begin
          out_valid <= 1'b1;
          out_data  <= derotate(hyp, sym_i, sym_q);
          out_first <= (pos == '0);
          out_last  <= (pos == PW'(PAYLOAD_LEN - 1));
        end

        case (state)
          ST_HUNT: begin
            if (hit) begin
              hyp       <= best_hyp;
              pos       <= '0;
              conf      <= CW'(1);
              miss      <= '0;
              sof_pulse <= 1'b1;
              state     <= (CONFIRM == 1) ? ST_LOCK : ST_VERIFY;
            end
          end
          ST_VERIFY: begin
            if (at_end) begin
              if (!hit) begin
                state <= ST_HUNT;
              end else begin
                sof_pulse <= 1'b1;
                if (best_hyp != hyp) begin
                  hyp  <= best_hyp;
                  conf <= CW'(1);
                end else if (conf_inc == CW'(CONFIRM)) begin
                  conf  <= conf_inc;
                  miss  <= '0;
                  state <= ST_LOCK;
                end else begin
                  conf <= conf_inc;
                end
              end
            end
          end
          ST_LOCK: begin
            if (at_end) begin
              if (hit) begin
                miss      <= '0;
                sof_pulse <= 1'b1;
                if (best_hyp != hyp) begin
                  hyp        <= best_hyp;
                  hyp_change <= 1'b1;
                end
              end else if (miss_inc == MW'(MISS_MAX)) begin
                state <= ST_HUNT;
              end else begin
                miss <= miss_inc;
              end
            end
          end
          default: state <= ST_HUNT;
        endcase
      end
    end
  end

  assign locked     = (state == ST_LOCK);
  assign sync_state = state;
  assign rot        = hyp.rot;
`ifdef FRAME_SYNC_SWAP_EN
  assign swap       = hyp.swap;
`else
  assign swap       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_qpsk_frame_sync.sv
// ============================================================================
//  Module   : tb_qpsk_frame_sync
//  Purpose  : Self-checking bench for qpsk_frame_sync with payload scoreboard.
//             Optional swap scenario under FRAME_SYNC_SWAP_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_qpsk_frame_sync;

  localparam int          SOF_LEN     = 26;
  localparam int          PAYLOAD_LEN = 63;
  localparam logic [25:0] SOF_I_C     = 26'h3278428;
  localparam logic [25:0] SOF_Q_C     = 26'h272d17d;

  logic       clk = 1'b0;
  logic       rst;
  logic       sym_valid;
  logic       sym_i;
  logic       sym_q;
  logic       out_valid;
  logic [1:0] out_data;
  logic       out_first;
  logic       out_last;
  logic       sof_pulse;
  logic       locked;
  logic [1:0] sync_state;
  logic [1:0] rot;
  logic       swap;
  logic       hyp_change;
  logic [5:0] score;

  typedef struct packed {
    logic [1:0] data;
    logic       first;
    logic       last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  bit   gaps_on  = 1'b0;

  qpsk_frame_sync dut (
    .clk        (clk),
    .rst        (rst),
    .sym_valid  (sym_valid),
    .sym_i      (sym_i),
    .sym_q      (sym_q),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_first  (out_first),
    .out_last   (out_last),
    .sof_pulse  (sof_pulse),
    .locked     (locked),
    .sync_state (sync_state),
    .rot        (rot),
    .swap       (swap),
    .hyp_change (hyp_change),
    .score      (score)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Channel model: optional I/Q swap, then r quarter turns of (i,q) -> (~q,i).
  function automatic logic [1:0] tx_to_rx(input logic [1:0] r, input bit sw, input logic [1:0] tx);
    logic i, q, t;
    i = sw ? tx[0] : tx[1];
    q = sw ? tx[1] : tx[0];
    for (int n = 0; n < int'(r); n++) begin
      t = i;
      i = ~q;
      q = t;
    end
    return {i, q};
  endfunction

  task automatic send_sym(input logic [1:0] s);
    int g;
    if (gaps_on) begin
      g = $urandom_range(0, 2);
      repeat (g) begin
        @(negedge clk);
        sym_valid = 1'b0;
        sym_i     = 1'($urandom);
        sym_q     = 1'($urandom);
      end
    end
    @(negedge clk);
    sym_valid = 1'b1;
    sym_i     = s[1];
    sym_q     = s[0];
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sym_valid = 1'b0;
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst       = 1'b1;
    sym_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One SOF (with nerr I-bit errors) then npay payload symbols; checks status after the SOF end.
  task automatic send_frame(input logic [1:0] r, input bit sw, input int nerr,
                            input logic [1:0] exp_state, input bit exp_sof, input bit exp_hc,
                            input logic [1:0] exp_rot, input bit exp_out, input int npay,
                            input int exp_score);
    logic [25:0] si, sq;
    logic [1:0]  tx, rx;
    si = SOF_I_C;
    sq = SOF_Q_C;
    for (int k = 0; k < SOF_LEN; k++) begin
      tx = {si[SOF_LEN-1-k], sq[SOF_LEN-1-k]};
      rx = tx_to_rx(r, sw, tx);
      if (k < nerr) rx[1] = ~rx[1];
      send_sym(rx);
    end
    @(posedge clk);
    #1;
    check_eq("sof_pulse", 32'(sof_pulse), 32'(exp_sof));
    check_eq("sync_state", 32'(sync_state), 32'(exp_state));
    check_eq("locked", 32'(locked), 32'(exp_state == 2'd2));
    check_eq("rot", 32'(rot), 32'(exp_rot));
    check_eq("hyp_change", 32'(hyp_change), 32'(exp_hc));
    check_eq("swap", 32'(swap), 32'(sw));
    if (exp_score >= 0) check_eq("score", 32'(score), exp_score);
    for (int p = 0; p < npay; p++) begin
      tx = 2'($urandom);
      rx = tx_to_rx(r, sw, tx);
      if (exp_out) sb.push_back('{data: tx, first: (p == 0), last: (p == PAYLOAD_LEN - 1)});
      send_sym(rx);
    end
  endtask

  // Output monitor: every emitted payload symbol must match the scoreboard head.
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_out", 32'(out_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("out_data", 32'(out_data), 32'(mon_e.data));
        check_eq("out_first", 32'(out_first), 32'(mon_e.first));
        check_eq("out_last", 32'(out_last), 32'(mon_e.last));
      end
    end
  end

  initial begin
    rst       = 1'b1;
    sym_valid = 1'b0;
    sym_i     = 1'b0;
    sym_q     = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_state", 32'(sync_state), 32'd0);
    check_eq("rst_locked", 32'(locked), 32'd0);
    check_eq("rst_score", 32'(score), 32'd0);
    check_eq("rst_sof", 32'(sof_pulse), 32'd0);
    check_eq("rst_rot", 32'(rot), 32'd0);
    rst = 1'b0;

    // Clean acquisition, r0, four back-to-back frames.
    send_frame(2'd0, 1'b0, 0, 2'd1, 1'b1, 1'b0, 2'd0, 1'b1, PAYLOAD_LEN, 52);
    send_frame(2'd0, 1'b0, 0, 2'd2, 1'b1, 1'b0, 2'd0, 1'b1, PAYLOAD_LEN, 52);
    send_frame(2'd0, 1'b0, 0, 2'd2, 1'b1, 1'b0, 2'd0, 1'b1, PAYLOAD_LEN, 52);
    send_frame(2'd0, 1'b0, 0, 2'd2, 1'b1, 1'b0, 2'd0, 1'b1, PAYLOAD_LEN, 52);

    // Flywheel: two misses tolerated, a good SOF clears them, three misses drop to HUNT.
    send_frame(2'd0, 1'b0, 10, 2'd2, 1'b0, 1'b0, 2'd0, 1'b1, PAYLOAD_LEN, 42);
    send_frame(2'd0, 1'b0, 10, 2'd2, 1'b0, 1'b0, 2'd0, 1'b1, PAYLOAD_LEN, 42);
    send_frame(2'd0, 1'b0, 0,  2'd2, 1'b1, 1'b0, 2'd0, 1'b1, PAYLOAD_LEN, 52);
    send_frame(2'd0, 1'b0, 10, 2'd2, 1'b0, 1'b0, 2'd0, 1'b1, PAYLOAD_LEN, 42);
    send_frame(2'd0, 1'b0, 10, 2'd2, 1'b0, 1'b0, 2'd0, 1'b1, PAYLOAD_LEN, 42);
    send_frame(2'd0, 1'b0, 10, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, PAYLOAD_LEN, 42);

    // Re-acquire, then phase slip to r1 at a SOF boundary.
    send_frame(2'd0, 1'b0, 0, 2'd1, 1'b1, 1'b0, 2'd0, 1'b1, PAYLOAD_LEN, 52);
    send_frame(2'd0, 1'b0, 0, 2'd2, 1'b1, 1'b0, 2'd0, 1'b1, PAYLOAD_LEN, 52);
    send_frame(2'd1, 1'b0, 0, 2'd2, 1'b1, 1'b1, 2'd1, 1'b1, PAYLOAD_LEN, 52);
    send_frame(2'd1, 1'b0, 0, 2'd2, 1'b1, 1'b0, 2'd1, 1'b1, PAYLOAD_LEN, 52);

    // Random sym_valid gaps must not change the emitted payload.
    gaps_on = 1'b1;
    send_frame(2'd1, 1'b0, 0, 2'd2, 1'b1, 1'b0, 2'd1, 1'b1, PAYLOAD_LEN, 52);
    send_frame(2'd1, 1'b0, 0, 2'd2, 1'b1, 1'b0, 2'd1, 1'b1, PAYLOAD_LEN, 52);
    gaps_on = 1'b0;

    // Reset arriving with payload index 30.
    send_frame(2'd1, 1'b0, 0, 2'd2, 1'b1, 1'b0, 2'd1, 1'b1, 30, 52);
    @(negedge clk);
    rst       = 1'b1;
    sym_valid = 1'b1;
    sym_i     = 1'($urandom);
    sym_q     = 1'($urandom);
    @(posedge clk);
    #1;
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_out_last", 32'(out_last), 32'd0);
    check_eq("midrst_state", 32'(sync_state), 32'd0);
    check_eq("midrst_locked", 32'(locked), 32'd0);
    check_eq("midrst_rot", 32'(rot), 32'd0);
    check_eq("midrst_score", 32'(score), 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    sym_valid = 1'b0;

    // Acquisition of an r2-rotated stream.
    send_frame(2'd2, 1'b0, 0, 2'd1, 1'b1, 1'b0, 2'd2, 1'b1, PAYLOAD_LEN, 52);
    send_frame(2'd2, 1'b0, 0, 2'd2, 1'b1, 1'b0, 2'd2, 1'b1, PAYLOAD_LEN, 52);

    // Threshold boundary: 4 errors hit, 5 errors do not.
    do_reset;
    send_frame(2'd0, 1'b0, 4, 2'd1, 1'b1, 1'b0, 2'd0, 1'b1, PAYLOAD_LEN, 48);
    do_reset;
    send_frame(2'd0, 1'b0, 5, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, PAYLOAD_LEN, 47);
    idle(2);
    check_eq("thresh_hunt_hold", 32'(sync_state), 32'd0);

`ifdef FRAME_SYNC_SWAP_EN
    do_reset;
    send_frame(2'd0, 1'b1, 0, 2'd1, 1'b1, 1'b0, 2'd0, 1'b1, PAYLOAD_LEN, 52);
    send_frame(2'd0, 1'b1, 0, 2'd2, 1'b1, 1'b0, 2'd0, 1'b1, PAYLOAD_LEN, 52);
`endif

    idle(4);
    check_eq("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
